// File: rtl/pkt_pkg.sv
// pkt_pkg: shared types and default constants for the packet receive path.
// Used by pkt_deserializer, its bus interface and pkt_hold_reg.
package pkt_pkg;

    // Framing states: HUNT searches for the sync word, RECV counts out the packet body.
    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } pkt_state_t;

    localparam int              PKT_W_DEF     = 64;
    localparam int              SYNC_W_DEF    = 4;
    localparam logic [SYNC_W_DEF-1:0] SYNC_WORD_DEF = 4'b1111;

endpackage

// File: rtl/pkt_deserializer_if.sv
// pkt_deserializer_if: serial input side and packet hand-off side of the deserializer.
// The slave modport is the deserializer; the master modport is whoever drives the bits
// and consumes packets. par_err exists only when PKT_PARITY_CHECK_EN is defined.
interface pkt_deserializer_if
    import pkt_pkg::*;
#(
    parameter int PKT_W = PKT_W_DEF
);
    logic             din;
    logic             en;
    logic             pkt_rst;
    logic [PKT_W-1:0] dout;
    logic             pkt_valid;
    logic             pkt_ready;
    logic             busy;
    logic             ovf;
`ifdef PKT_PARITY_CHECK_EN
    logic             par_err;

    modport master (
        output din, en, pkt_rst, pkt_ready,
        input  dout, pkt_valid, busy, ovf, par_err
    );

    modport slave (
        input  din, en, pkt_rst, pkt_ready,
        output dout, pkt_valid, busy, ovf, par_err
    );
`else
    modport master (
        output din, en, pkt_rst, pkt_ready,
        input  dout, pkt_valid, busy, ovf
    );

    modport slave (
        input  din, en, pkt_rst, pkt_ready,
        output dout, pkt_valid, busy, ovf
    );
`endif

endinterface

// File: rtl/pkt_hold_reg.sv
// pkt_hold_reg: single-entry valid/ready holding register with sticky overflow.
// A load is taken when the register is empty or being drained in the same cycle;
// otherwise the incoming word is dropped and ovf is set until clr_ovf.
module pkt_hold_reg
    import pkt_pkg::*;
#(
    parameter int W = PKT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         ready,
    input  logic         clr_ovf,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         ovf
);

    // Hold the packet until the consumer takes it; flag packets that arrive while full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout  <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load) begin
                if (!valid || ready) begin
                    dout  <= data;
                    valid <= 1'b1;
                end else begin
                    ovf   <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pkt_deserializer.sv
// pkt_deserializer: hunts for SYNC_WORD in a serial stream, collects PKT_W bits
// (sync included, first bit ends up in the MSB) and hands the packet to pkt_hold_reg.
// Optional build macro PKT_PARITY_CHECK_EN: drop packets with odd overall parity and
// pulse par_err for one cycle instead.
module pkt_deserializer
    import pkt_pkg::*;
#(
    parameter int              PKT_W     = PKT_W_DEF,
    parameter int              SYNC_W    = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input logic               clk,
    input logic               rst,
    pkt_deserializer_if.slave bus
);

    localparam int             CW       = $clog2(PKT_W + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(PKT_W - 1);
    localparam logic [CW-1:0]  SYNC_CNT = CW'(SYNC_W);
    // The window and shift register only keep history; the newest bit comes straight from din.
    localparam int             HW       = (SYNC_W > 1) ? SYNC_W - 1 : 1;

    pkt_state_t        state;
    logic [HW-1:0]     win;
    logic [PKT_W-2:0]  shreg;
    logic [CW-1:0]     cnt;

    logic [HW:0]       win_ext;
    logic [SYNC_W-1:0] win_nxt;
    logic [PKT_W-1:0]  pkt_data;
    logic              done;
    logic              load;

    assign win_ext  = {win, bus.din};
    assign win_nxt  = win_ext[SYNC_W-1:0];
    assign pkt_data = {shreg, bus.din};
    assign done     = (state == RECV) && bus.en && !bus.pkt_rst && (cnt == LAST_CNT);
    assign bus.busy = (state == RECV);

    // Framing FSM: sync hunt, bit counting and abort handling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HUNT;
            win   <= '0;
            shreg <= '0;
            cnt   <= '0;
        end else if (bus.pkt_rst) begin
            state <= HUNT;
            win   <= '0;
            shreg <= '0;
            cnt   <= '0;
        end else if (bus.en) begin
            case (state)
                HUNT: begin
                    win <= win_ext[HW-1:0];
                    if (win_nxt == SYNC_WORD) begin
                        state <= RECV;
                        shreg <= (PKT_W-1)'(SYNC_WORD);
                        cnt   <= SYNC_CNT;
                    end
                end
                RECV: begin
                    shreg <= pkt_data[PKT_W-2:0];
                    cnt   <= cnt + 1'b1;
                    if (done) begin
                        state <= HUNT;
                        win   <= '0;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

`ifdef PKT_PARITY_CHECK_EN
    logic par_bad;

    assign par_bad = ^pkt_data;
    assign load    = done && !par_bad;

    // One-cycle error pulse for each completed packet that fails even parity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.par_err <= 1'b0;
        end else begin
            bus.par_err <= done && par_bad;
        end
    end
`else
    assign load = done;
`endif

    pkt_hold_reg #(
        .W (PKT_W)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data    (pkt_data),
        .ready   (bus.pkt_ready),
        .clr_ovf (bus.pkt_rst),
        .dout    (bus.dout),
        .valid   (bus.pkt_valid),
        .ovf     (bus.ovf)
    );

endmodule

// File: tb/tb_pkt_deserializer.sv
// tb_pkt_deserializer: directed bench for pkt_deserializer with a packet scoreboard.
// Covers sync hunt, back-pressure/overflow, simultaneous accept, abort, gapped input,
// async reset and, when PKT_PARITY_CHECK_EN is defined, the parity filter.
module tb_pkt_deserializer;
    import pkt_pkg::*;

    localparam int PKT_W = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pkt_deserializer_if #(.PKT_W(PKT_W)) bus ();

    pkt_deserializer #(
        .PKT_W     (PKT_W),
        .SYNC_W    (4),
        .SYNC_WORD (4'b1111)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] sb_q[$];
    logic [63:0] held;
    logic [63:0] pkt1;
    logic [63:0] p2, p3, p4, p5, p7;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare dout against the oldest expected packet in the scoreboard.
    task automatic check_pkt(input string tag);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected <scoreboard empty>", tag, bus.dout);
        end else begin
            exp = sb_q.pop_front();
            check_output(tag, bus.dout, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic b);
        bus.din = b;
        bus.en  = 1'b1;
        tick();
        bus.en  = 1'b0;
        bus.din = 1'b0;
    endtask

    // Send v[n-1] down to v[0], with `gap` idle cycles between bits.
    task automatic send_bits(input logic [63:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            apply_stimulus(v[i]);
            if (i > 0) repeat (gap) tick();
        end
    endtask

    task automatic pulse_ready();
        bus.pkt_ready = 1'b1;
        tick();
        bus.pkt_ready = 1'b0;
    endtask

    // Build a packet from a payload; in parity builds fix the last bit to even parity.
    function automatic logic [63:0] mk_pkt(input logic [59:0] p);
        logic [63:0] r;
        r = {4'hF, p};
`ifdef PKT_PARITY_CHECK_EN
        r[0] = ^r[63:1];
`endif
        return r;
    endfunction

    initial begin
        bus.din       = 1'b0;
        bus.en        = 1'b0;
        bus.pkt_rst   = 1'b0;
        bus.pkt_ready = 1'b0;
        pkt1 = 64'hFAAA_AAAA_AAAA_AAAA;
        p2   = mk_pkt(60'h123_4567_89AB_CDEF);
        p3   = mk_pkt(60'h0F0_F0F0_F0F0_F0F0);
        p4   = mk_pkt(60'hDEA_DBEE_F012_3456);
        p5   = mk_pkt(60'h5A5_A5A5_1234_5678);
        p7   = mk_pkt(60'hCAF_E000_BABE_0001);

        // Reset state
        #12;
        check_output("rst_dout",  bus.dout, 64'h0);
        check_output("rst_valid", {63'h0, bus.pkt_valid}, 64'h0);
        check_output("rst_busy",  {63'h0, bus.busy}, 64'h0);
        check_output("rst_ovf",   {63'h0, bus.ovf}, 64'h0);
        rst = 1'b1;

        // Sync hunt: 0,0,1,1,1,1 then 60 alternating bits
        $display("[TB] sync hunt");
        send_bits(64'b0011, 4, 0);
        send_bits(64'b1, 1, 0);
        check_output("hunt_busy_5", {63'h0, bus.busy}, 64'h0);
        send_bits(64'b1, 1, 0);
        check_output("hunt_busy_6", {63'h0, bus.busy}, 64'h1);
        send_bits(pkt1 >> 1, 59, 0);
        check_output("hunt_valid_early", {63'h0, bus.pkt_valid}, 64'h0);
        check_output("hunt_busy_mid", {63'h0, bus.busy}, 64'h1);
        sb_q.push_back(pkt1);
        send_bits(pkt1, 1, 0);
        check_output("hunt_valid", {63'h0, bus.pkt_valid}, 64'h1);
        check_output("hunt_busy_end", {63'h0, bus.busy}, 64'h0);
        check_pkt("hunt_dout");
        held = pkt1;

        // Back-pressure: second packet is dropped while the first is held
        $display("[TB] overflow");
        send_bits(p2, 64, 0);
        check_output("ovf_dout", bus.dout, held);
        check_output("ovf_valid", {63'h0, bus.pkt_valid}, 64'h1);
        check_output("ovf_flag", {63'h0, bus.ovf}, 64'h1);
        pulse_ready();
        check_output("ovf_drain_valid", {63'h0, bus.pkt_valid}, 64'h0);
        check_output("ovf_sticky", {63'h0, bus.ovf}, 64'h1);

        // Simultaneous accept: completion in the same cycle as valid & ready
        $display("[TB] simultaneous accept");
        bus.pkt_rst = 1'b1;
        tick();
        bus.pkt_rst = 1'b0;
        check_output("abort_clr_ovf", {63'h0, bus.ovf}, 64'h0);
        sb_q.push_back(p3);
        send_bits(p3, 64, 0);
        check_output("p3_valid", {63'h0, bus.pkt_valid}, 64'h1);
        check_pkt("p3_dout");
        sb_q.push_back(p4);
        send_bits(p4 >> 1, 63, 0);
        bus.pkt_ready = 1'b1;
        send_bits(p4, 1, 0);
        bus.pkt_ready = 1'b0;
        check_output("simul_valid", {63'h0, bus.pkt_valid}, 64'h1);
        check_output("simul_ovf", {63'h0, bus.ovf}, 64'h0);
        check_pkt("simul_dout");
        held = p4;

        // Abort after 20 bits; held packet must survive
        $display("[TB] abort");
        send_bits(p5 >> 44, 20, 0);
        check_output("abort_busy_pre", {63'h0, bus.busy}, 64'h1);
        bus.pkt_rst = 1'b1;
        bus.en      = 1'b1;
        bus.din     = 1'b1;
        tick();
        bus.pkt_rst = 1'b0;
        bus.en      = 1'b0;
        bus.din     = 1'b0;
        check_output("abort_busy", {63'h0, bus.busy}, 64'h0);
        check_output("abort_valid", {63'h0, bus.pkt_valid}, 64'h1);
        check_output("abort_dout", bus.dout, held);
        pulse_ready();
        check_output("abort_drain", {63'h0, bus.pkt_valid}, 64'h0);
        sb_q.push_back(p5);
        send_bits(p5, 64, 0);
        check_output("p5_valid", {63'h0, bus.pkt_valid}, 64'h1);
        check_pkt("p5_dout");

        // Gapped input: one bit every third cycle
        $display("[TB] gapped input");
        pulse_ready();
        sb_q.push_back(pkt1);
        send_bits(pkt1, 64, 2);
        check_output("gap_valid", {63'h0, bus.pkt_valid}, 64'h1);
        check_pkt("gap_dout");

        // Async reset mid-packet with a held packet and ovf set
        $display("[TB] async reset");
        send_bits(p7, 64, 0);
        check_output("pre_rst_ovf", {63'h0, bus.ovf}, 64'h1);
        send_bits(p5 >> 40, 24, 0);
        #2;
        rst = 1'b0;
        #1;
        check_output("arst_dout", bus.dout, 64'h0);
        check_output("arst_valid", {63'h0, bus.pkt_valid}, 64'h0);
        check_output("arst_busy", {63'h0, bus.busy}, 64'h0);
        check_output("arst_ovf", {63'h0, bus.ovf}, 64'h0);
        #4;
        rst = 1'b1;
        tick();

`ifdef PKT_PARITY_CHECK_EN
        // Parity filter: odd packet discarded with a one-cycle par_err pulse
        $display("[TB] parity check");
        send_bits({4'hF, 60'h1}, 64, 0);
        check_output("par_err_pulse", {63'h0, bus.par_err}, 64'h1);
        check_output("par_bad_valid", {63'h0, bus.pkt_valid}, 64'h0);
        tick();
        check_output("par_err_low", {63'h0, bus.par_err}, 64'h0);
        sb_q.push_back(mk_pkt(60'h1));
        send_bits(mk_pkt(60'h1), 64, 0);
        check_output("par_ok_valid", {63'h0, bus.pkt_valid}, 64'h1);
        check_output("par_ok_err", {63'h0, bus.par_err}, 64'h0);
        check_pkt("par_ok_dout");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
